out_port: RTL and testbench

OUT_PORT -- requirements
Module: out_port

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/out_port.sv | 65 ++++++
 tb/tb_out_port.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-slice definitions: default widths/sizes and the external-port
// address helper used by both the register file and the output port.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N_REG = 8;
    localparam int DEFAULT_DEPTH = 4;

    // The top register address is not stored in the register file; it maps to
    // the external output port instead.
    function automatic int ext_addr(input int n_reg);
        return n_reg - 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty/count derive
// only from registered state, read data comes from the head entry.
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; stale entries are never visible while cnt is 0,
    // and leaving it unreset lets the array map onto plain RAM/flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at their bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/out_port.sv
// External output port: decodes datapath writes to the top register address
// into a FIFO drained by a valid/ready user interface, with sticky overflow.
module out_port
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REG = DEFAULT_N_REG,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(N_REG),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    a,
    input  logic             ce,
    input  logic [WIDTH-1:0] in,
    output logic             full,
    output logic [WIDTH-1:0] user_out,
    output logic             user_valid,
    input  logic             user_ready,
    output logic [LW-1:0]    level,
    output logic             overflow
);

    localparam logic [AW-1:0] EXT_A = AW'(ext_addr(N_REG));

    logic             ext_wr;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] head;
    logic             overflow_q;

    assign ext_wr = ce && (a == EXT_A);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ext_wr),
        .pop   (user_ready),
        .wdata (in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    // A write against a full buffer is lost even if the user pops that same
    // cycle: fullness is judged on the registered count, not the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (ext_wr && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign full       = fifo_full;
    assign user_valid = !fifo_empty;
    assign user_out   = user_valid ? head : '0;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_out_port.sv
// Scoreboard bench for out_port: stimulus pushes expected data into a queue,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_out_port;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic       ce;
    logic [7:0] din;
    logic       full;
    logic [7:0] user_out;
    logic       user_valid;
    logic       user_ready;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         mdl_lvl = 0;
    logic       mdl_ovf = 1'b0;

    out_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .ce         (ce),
        .in         (din),
        .full       (full),
        .user_out   (user_out),
        .user_valid (user_valid),
        .user_ready (user_ready),
        .level      (level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && user_valid && user_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_without_expected_entry", 32'(user_valid), 32'd0);
                end else begin
                    check("pop_data", 32'(user_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (mdl_lvl > 0 && exp_q.size() > 0) ? exp_q[0] : 8'h00;
        check({tag, ".level"},      32'(level),      32'(mdl_lvl));
        check({tag, ".full"},       32'(full),       32'(mdl_lvl == 4));
        check({tag, ".user_valid"}, 32'(user_valid), 32'(mdl_lvl != 0));
        check({tag, ".overflow"},   32'(overflow),   32'(mdl_ovf));
        check({tag, ".user_out"},   32'(user_out),   32'(head));
    endtask

    // Called at posedge+1; drives one cycle of inputs, updates the model,
    // then checks the registered outputs just after the next posedge.
    task automatic cycle(input logic c, input logic [2:0] aa, input logic [7:0] d,
                         input logic r, input string tag);
        logic wr;
        int   nxt;
        ce = c; a = aa; din = d; user_ready = r;
        wr  = c && (aa == 3'd7);
        nxt = mdl_lvl;
        if (wr && mdl_lvl < 4) begin
            exp_q.push_back(d);
            nxt++;
        end
        if (wr && mdl_lvl == 4) mdl_ovf = 1'b1;
        if (r && mdl_lvl > 0) nxt--;
        @(posedge clk);
        #1;
        mdl_lvl = nxt;
        ce = 1'b0; user_ready = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; a = '0; din = '0; user_ready = 1'b0;
        #2;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, held with user_ready low.
        cycle(1'b1, 3'd7, 8'hA5, 1'b0, "wr_a5");
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 8'h00, 1'b0, "hold_a5");
        cycle(1'b0, 3'd0, 8'h00, 1'b1, "drain_a5");

        // Fill to full, then an overflowing write while the user pops.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 3'd7, 8'(i), 1'b0, "fill");
        cycle(1'b1, 3'd7, 8'h05, 1'b1, "overflow_wr");
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, "drain_fill");
        cycle(1'b0, 3'd0, 8'h00, 1'b1, "underflow_ready");

        // Simultaneous push and pop at level 2.
        cycle(1'b1, 3'd7, 8'h20, 1'b0, "pp_a");
        cycle(1'b1, 3'd7, 8'h21, 1'b0, "pp_b");
        cycle(1'b1, 3'd7, 8'h10, 1'b1, "push_pop");
        for (int i = 0; i < 2; i++) cycle(1'b0, 3'd0, 8'h00, 1'b1, "drain_pp");

        // Register-file addresses never reach the port.
        for (int i = 0; i < 7; i++) cycle(1'b1, 3'(i), 8'hEE, 1'b0, "regfile_wr");

        // Push/pop pairs to walk the pointers past the wrap point.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 3'd7, 8'(8'h40 + i), 1'b0, "wrap_push");
            cycle(1'b0, 3'd0, 8'h00, 1'b1, "wrap_pop");
        end

        // Asynchronous reset with three entries buffered.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd7, 8'(8'h50 + i), 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        mdl_lvl = 0;
        mdl_ovf = 1'b0;
        check_state("async_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 3'd7, 8'h3C, 1'b0, "post_rst_wr");
        cycle(1'b0, 3'd0, 8'h00, 1'b1, "post_rst_pop");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
